mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Multicore RAM arbiter between NCORES cache pairs and the single shared RAM port. It accepts instruction-read, data-read and data-write requests from every core. Across cores it grants one transaction at a time in round-robin order. Within a core it uses fixed priority dREN > dWEN > iREN. It returns wait and load data to the granted core only, replacing single-core direct RAM control at the top of the multicore memory path.

## Interface
- NCORES, 2, number of cores (≥2); index width CW = $clog2(NCORES)
- WDOG_LIMIT, 255, BUSY-cycle abort threshold (used only under watchdog macro)

- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- iREN  in  NCORES  per-core instruction read request
- iaddr  in  NCORES×32  per-core instruction address (word_t)
- dREN  in  NCORES  per-core data read request
- dWEN  in  NCORES  per-core data write request
- daddr  in  NCORES×32  per-core data address
- dstore  in  NCORES×32  per-core write data
- iwait  out  NCORES  per-core instruction wait, 0 = done this cycle
- dwait  out  NCORES  per-core data wait, 0 = done this cycle
- iload  out  NCORES×32  instruction read data
- dload  out  NCORES×32  data read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR
- owner  out  CW  currently or last granted core
- arb_err  out  1  sticky watchdog abort flag

## Operation
- Two-state FSM: IDLE, BUSY.
- IDLE:
  - Scan cores from rr_ptr upward, with wrap-around; the first core with any request wins.
  - Register owner and src (SRC_DR / SRC_DW / SRC_I, chosen by in-core priority).
  - Register the selected address and store data into addr_q/data_q.
  - Go to BUSY.
  - With no request, stay IDLE with RAM enables 0.
- BUSY:
  - ramaddr = addr_q and ramstore = data_q.
  - ramREN = 1 for SRC_DR/SRC_I; ramWEN = 1 for SRC_DW.
- Completion: when ramstate == ACCESS in BUSY:
  - Owner's matching wait (dwait for SRC_DR/DW, iwait for SRC_I) = 0 for that cycle only.
  - Go to IDLE; rr_ptr ← owner+1 mod NCORES.
- Retraction: if the owner drops the granted request line while BUSY, go to IDLE next cycle with no ack and the same rr_ptr update.
- ERROR: ramstate == ERROR holds BUSY and the RAM request stays asserted (retry).
- Wait lines: all non-owner waits and all waits in IDLE are 1.
- Load data: iload[c] and dload[c] = ramload for every c, combinational; only the acked core may sample it.
- Simultaneous requests: several cores requesting in the same IDLE cycle resolve strictly by rr_ptr; losers keep wait = 1 and are served in later rotations, so no core starves.
- New requests arriving during BUSY are ignored until the next IDLE.

## Timing
- Reset values: state IDLE, rr_ptr 0, owner 0, addr_q/data_q 0, arb_err 0.
- Reset outputs: ramREN = ramWEN = 0, ramaddr = ramstore = 0, all waits 1.
- RST asserted mid-BUSY: next edge returns to IDLE; the in-flight transaction is dropped with no ack.
- Latency:
  - Request sampled at edge N (IDLE).
  - RAM enables high from cycle N+1.
  - Ack in the first BUSY cycle with ACCESS; minimum 2 cycles from request to wait=0.
- Arbitration takes one IDLE cycle between back-to-back transactions.
- Caches hold request, address and data stable until their wait is 0. The arbiter registers them anyway.

## Configuration
- MEM_ARB_WATCHDOG_EN defined:
  - An 8+-bit BUSY cycle counter clears on entry to BUSY.
  - When the counter reaches WDOG_LIMIT without ACCESS: abort to IDLE, no ack, advance rr_ptr, set arb_err (sticky until RST).
- Undefined: no counter; arb_err tied 0; BUSY waits indefinitely.

## Structure
- cpu_types_pkg gains src_t (SRC_I, SRC_DR, SRC_DW) and arb_state_t (IDLE, BUSY); ramstate_t and word_t are reused.
- Sub-module rr_picker: combinational rotate-priority encoder, NCORES request vector + rr_ptr → valid + winner index; instantiated once.

## Test plan
- Single request: core0 iREN, iaddr 0x40, RAM returns ACCESS on its 2nd BUSY cycle → iwait[0] = 0 exactly one cycle, 3 cycles after request; ramaddr 0x40; rr_ptr → 1.
- Contention: core0 and core1 dREN together from reset → core0 served first, then core1. With both held continuously, grants alternate 0,1,0,1.
- In-core priority: core1 dWEN (daddr 0x80, dstore 0xDEADBEEF) and iREN together → write first with ramWEN=1 and ramstore 0xDEADBEEF; iREN served in a later IDLE.
- Retraction: owner drops dREN mid-BUSY → IDLE next cycle, no dwait pulse, RAM enables 0.
- RST mid-BUSY: assert RST for 1 cycle during ramstate BUSY → all reset values next cycle, no ack.
- Watchdog (MEM_ARB_WATCHDOG_EN, WDOG_LIMIT 4): ramstate held BUSY → abort after 4 BUSY cycles, arb_err = 1 sticky, next core granted.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM handshake and arbiter types for the multicore memory path.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {SRC_I, SRC_DR, SRC_DW} src_t;
    // ARB_ prefix keeps these labels apart from the ramstate_t BUSY label in this scope
    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
    localparam int WDOG_MIN_W = 8;
endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: rotate-priority encoder; picks the first requester at or after i_ptr, wrapping.
module rr_picker #(
    parameter int N  = 2,
    parameter int CW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [CW-1:0] i_ptr,
    output logic          o_valid,
    output logic [CW-1:0] o_idx
);
    logic [CW-1:0] w_j;
    // Scan from the farthest slot back toward i_ptr so the closest requester wins last
    always_comb begin
        o_valid = |i_req;
        o_idx = '0;
        w_j = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_j = CW'((int'(i_ptr) + i) % N);
            if (i_req[w_j]) o_idx = w_j;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin RAM arbiter for NCORES cache pairs, in-core priority dREN > dWEN > iREN.
// Optional BUSY watchdog enabled by defining MEM_ARB_WATCHDOG_EN.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NCORES     = 2,
    parameter int WDOG_LIMIT = 255,
    localparam int CW        = $clog2(NCORES)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic       [NCORES-1:0]  iREN,
    input  word_t      [NCORES-1:0]  iaddr,
    input  logic       [NCORES-1:0]  dREN,
    input  logic       [NCORES-1:0]  dWEN,
    input  word_t      [NCORES-1:0]  daddr,
    input  word_t      [NCORES-1:0]  dstore,
    output logic       [NCORES-1:0]  iwait,
    output logic       [NCORES-1:0]  dwait,
    output word_t      [NCORES-1:0]  iload,
    output word_t      [NCORES-1:0]  dload,
    output logic                     ramREN,
    output logic                     ramWEN,
    output word_t                    ramaddr,
    output word_t                    ramstore,
    input  word_t                    ramload,
    input  ramstate_t                ramstate,
    output logic       [CW-1:0]      owner,
    output logic                     arb_err
);
    arb_state_t    r_state, w_next;
    logic [CW-1:0] r_rr_ptr, r_owner, w_win, w_ptr_next;
    src_t          r_src, w_src;
    word_t         r_addr, r_data;
    logic [NCORES-1:0] w_req;
    logic          w_valid, w_hold, w_ack, w_timeout, w_grant, w_done, w_busy;

    assign w_req = iREN | dREN | dWEN;

    rr_picker #(.N(NCORES), .CW(CW)) u_pick (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_valid),
        .o_idx   (w_win)
    );

    assign w_busy     = r_state == ARB_BUSY;
    assign w_src      = dREN[w_win] ? SRC_DR : dWEN[w_win] ? SRC_DW : SRC_I;
    assign w_hold     = r_src == SRC_DR ? dREN[r_owner] : r_src == SRC_DW ? dWEN[r_owner] : iREN[r_owner];
    // A retracted request is never acked, even if the RAM answers that same cycle
    assign w_ack      = w_busy && w_hold && ramstate == ACCESS;
    assign w_ptr_next = r_owner == CW'(NCORES - 1) ? '0 : r_owner + CW'(1);

`ifdef MEM_ARB_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_LIMIT + 1) > WDOG_MIN_W ? $clog2(WDOG_LIMIT + 1) : WDOG_MIN_W;
    logic [WW-1:0] r_wdog;
    logic          r_arb_err;
    // r_wdog counts BUSY cycles already spent; it sits at 0 in IDLE so entry clears it
    assign w_timeout = w_busy && w_hold && !w_ack && r_wdog == WW'(WDOG_LIMIT - 1);
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wdog <= '0;
            r_arb_err <= 1'b0;
        end else begin
            r_wdog <= w_busy ? r_wdog + WW'(1) : '0;
            if (w_timeout) r_arb_err <= 1'b1;
        end
    end
    assign arb_err = r_arb_err;
`else
    assign w_timeout = 1'b0;
    assign arb_err   = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        w_grant = 1'b0;
        w_done = 1'b0;
        if (r_state == ARB_IDLE) begin
            w_grant = w_valid;
            w_next = w_valid ? ARB_BUSY : ARB_IDLE;
        end else begin
            w_done = w_ack || !w_hold || w_timeout;
            w_next = w_done ? ARB_IDLE : ARB_BUSY;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ARB_IDLE;
            r_rr_ptr <= '0;
            r_owner <= '0;
            r_src <= SRC_I;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_owner <= w_win;
                r_src <= w_src;
                r_addr <= w_src == SRC_I ? iaddr[w_win] : daddr[w_win];
                r_data <= dstore[w_win];
            end
            if (w_done) r_rr_ptr <= w_ptr_next;
        end
    end

    assign ramREN   = w_busy && r_src != SRC_DW;
    assign ramWEN   = w_busy && r_src == SRC_DW;
    assign ramaddr  = w_busy ? r_addr : '0;
    assign ramstore = w_busy ? r_data : '0;
    assign owner    = r_owner;
    assign iload    = {NCORES{ramload}};
    assign dload    = {NCORES{ramload}};

    for (genvar c = 0; c < NCORES; c++) begin : g_wait
        assign iwait[c] = !(w_ack && r_owner == CW'(c) && r_src == SRC_I);
        assign dwait[c] = !(w_ack && r_owner == CW'(c) && r_src != SRC_I);
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter (2 cores, WDOG_LIMIT 4).
module tb_mem_arbiter;
    import cpu_types_pkg::*;
    localparam int NC = 2;

    typedef struct {
        int    core;
        src_t  src;
        word_t addr;
        word_t data;
    } exp_t;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [NC-1:0]     iREN, dREN, dWEN, iwait, dwait;
    word_t [NC-1:0]    iaddr, daddr, dstore, iload, dload;
    logic              ramREN, ramWEN, arb_err;
    word_t             ramaddr, ramstore, ramload;
    ramstate_t         ramstate;
    logic [0:0]        owner;
    exp_t              sb[$];
    int                n_pass = 0;
    int                n_total = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.NCORES(NC), .WDOG_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .owner(owner), .arb_err(arb_err)
    );

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called one tick after the grant edge; stalls nbusy cycles, then answers ACCESS
    task automatic serve(int nbusy);
        exp_t e;
        logic [NC-1:0] m, ei, ed;
        for (int k = 0; k < nbusy; k++) begin
            ramstate = BUSY;
            #1;
            chk("busy_iwait", iwait, 3);
            chk("busy_dwait", dwait, 3);
            cyc();
        end
        ramstate = ACCESS;
        ramload = $urandom;
        #1;
        if (sb.size() == 0) begin
            n_total++;
            $error("FAIL sb_empty: observed an ack expected none queued");
        end else begin
            e = sb.pop_front();
            m = 2'b01 << e.core;
            ei = e.src == SRC_I ? ~m : 2'b11;
            ed = e.src != SRC_I ? ~m : 2'b11;
            chk("owner", owner, e.core);
            chk("ack_iwait", iwait, ei);
            chk("ack_dwait", dwait, ed);
            chk("ramREN", ramREN, e.src != SRC_DW);
            chk("ramWEN", ramWEN, e.src == SRC_DW);
            chk("ramaddr", ramaddr, e.addr);
            if (e.src == SRC_DW) chk("ramstore", ramstore, e.data);
            chk("load", e.src == SRC_I ? iload[e.core] : dload[e.core], ramload);
        end
        cyc();
        ramstate = FREE;
        #1;
        chk("post_iwait", iwait, 3);
        chk("post_dwait", dwait, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal;
    end

    initial begin
        iREN = '0; dREN = '0; dWEN = '0; iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = FREE;
        cyc();
        cyc();
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_ramstore", ramstore, 0);
        chk("rst_iwait", iwait, 3);
        chk("rst_dwait", dwait, 3);
        chk("rst_owner", owner, 0);
        chk("rst_arb_err", arb_err, 0);
        RST = 1'b0;
        cyc();

        // single instruction read, ACCESS on 2nd BUSY cycle
        iREN[0] = 1'b1;
        iaddr[0] = 32'h40;
        sb.push_back('{0, SRC_I, 32'h40, 32'h0});
        #1;
        chk("idle_iwait", iwait, 3);
        chk("idle_ramREN", ramREN, 0);
        cyc();
        serve(1);
        iREN[0] = 1'b0;

        // rr_ptr is now 1: core1 wins a tie
        dREN = 2'b11;
        daddr[0] = 32'h100;
        daddr[1] = 32'h200;
        sb.push_back('{1, SRC_DR, 32'h200, 32'h0});
        sb.push_back('{0, SRC_DR, 32'h100, 32'h0});
        cyc();
        serve(0);
        cyc();
        serve(0);
        dREN = '0;

        // contention from reset alternates 0,1,0,1
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        dREN = 2'b11;
        for (int k = 0; k < 4; k++) sb.push_back('{k % 2, SRC_DR, k % 2 ? 32'h200 : 32'h100, 32'h0});
        for (int k = 0; k < 4; k++) begin
            cyc();
            serve(k % 3);
        end
        dREN = '0;

        // in-core priority: write beats ifetch
        dWEN[1] = 1'b1;
        daddr[1] = 32'h80;
        dstore[1] = 32'hDEADBEEF;
        iREN[1] = 1'b1;
        iaddr[1] = 32'h44;
        sb.push_back('{1, SRC_DW, 32'h80, 32'hDEADBEEF});
        cyc();
        serve(1);
        dWEN[1] = 1'b0;
        sb.push_back('{1, SRC_I, 32'h44, 32'h0});
        cyc();
        serve(0);
        iREN[1] = 1'b0;

        // retraction mid-BUSY
        dREN[0] = 1'b1;
        daddr[0] = 32'h300;
        cyc();
        ramstate = BUSY;
        #1;
        chk("retr_ramREN", ramREN, 1);
        chk("retr_owner", owner, 0);
        dREN[0] = 1'b0;
        #1;
        chk("retr_dwait", dwait, 3);
        cyc();
        chk("retr_idle_ramREN", ramREN, 0);
        chk("retr_idle_ramWEN", ramWEN, 0);
        chk("retr_idle_dwait", dwait, 3);

        // ERROR holds the request; retraction advanced rr_ptr to 1
        dREN = 2'b11;
        daddr[0] = 32'h500;
        daddr[1] = 32'h510;
        sb.push_back('{1, SRC_DR, 32'h510, 32'h0});
        cyc();
        ramstate = ERROR;
        #1;
        chk("err_ramREN", ramREN, 1);
        chk("err_dwait", dwait, 3);
        chk("err_owner", owner, 1);
        cyc();
        chk("err_retry_ramREN", ramREN, 1);
        chk("err_retry_ramaddr", ramaddr, 32'h510);
        serve(0);
        dREN[1] = 1'b0;
        sb.push_back('{0, SRC_DR, 32'h500, 32'h0});
        cyc();
        serve(0);
        dREN = '0;

        // reset mid-BUSY drops the transaction
        iREN[1] = 1'b1;
        iaddr[1] = 32'h600;
        cyc();
        ramstate = BUSY;
        #1;
        chk("rstb_owner", owner, 1);
        chk("rstb_ramaddr", ramaddr, 32'h600);
        RST = 1'b1;
        iREN = '0;
        cyc();
        chk("rstb_ramREN", ramREN, 0);
        chk("rstb_ramaddr0", ramaddr, 0);
        chk("rstb_iwait", iwait, 3);
        chk("rstb_owner0", owner, 0);
        RST = 1'b0;
        ramstate = FREE;
        cyc();

`ifdef MEM_ARB_WATCHDOG_EN
        dREN = 2'b11;
        daddr[0] = 32'h700;
        daddr[1] = 32'h710;
        cyc();
        for (int k = 0; k < 4; k++) begin
            ramstate = BUSY;
            #1;
            chk("wdog_ramREN", ramREN, 1);
            chk("wdog_dwait", dwait, 3);
            chk("wdog_err_low", arb_err, 0);
            cyc();
        end
        chk("wdog_abort_ramREN", ramREN, 0);
        chk("wdog_arb_err", arb_err, 1);
        dREN[0] = 1'b0;
        sb.push_back('{1, SRC_DR, 32'h710, 32'h0});
        cyc();
        serve(0);
        dREN = '0;
        chk("wdog_sticky", arb_err, 1);
`else
        dREN[0] = 1'b1;
        daddr[0] = 32'h700;
        sb.push_back('{0, SRC_DR, 32'h700, 32'h0});
        cyc();
        serve(10);
        dREN = '0;
        chk("nowdog_arb_err", arb_err, 0);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
